cacheline_adapter: RTL and testbench

- Responder on the cache's downstream (dfp) port: accepts one 256-bit cache-line read or write from the cache, converts it into a 4-beat 64-bit burst on the memory (bmem) side, and returns a single-cycle dfp_resp.
- For reads, it assembles the returned beats into a full line on dfp_rdata.
- Sits between the pipelined cache and the burst memory model; exactly one transaction is in flight at a time.

---
 rtl/cacheline_adapter_if.sv | 43 ++++
 rtl/cacheline_adapter.sv | 173 +++++++++++++++++
 tb/tb_cacheline_adapter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
// ============================================================================
// cacheline_adapter_if : cache dfp port and burst-memory port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface cacheline_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  // adapter side
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid
  );

  // cache + memory side
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid
  );
endinterface

`default_nettype wire

// File: rtl/cacheline_adapter.sv
// ============================================================================
// cacheline_adapter : 256-bit cache line <-> 4-beat 64-bit memory burst.
// Optional macro CLA_PERF_CNT_EN adds saturating read/write completion counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adapter_if.slave  bus
`ifdef CLA_PERF_CNT_EN
  ,
  output logic [31:0]         perf_rd_cnt,
  output logic [31:0]         perf_wr_cnt
`endif
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [1:0]        cnt;
  logic [26:0]       addr_q;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rline;

  logic              bmem_read_d;
  logic              bmem_write_d;
  logic [BEAT_W-1:0] bmem_wdata_d;
  logic              dfp_resp_d;

  // Line offset bits are don't-care; the burst always starts line-aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, bus.dfp_addr[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d      = state;
    bmem_read_d  = 1'b0;
    bmem_write_d = 1'b0;
    bmem_wdata_d = '0;
    dfp_resp_d   = 1'b0;
    case (state)
      IDLE: begin
        // Write wins so a dirty victim is written back before the fill.
        if (bus.dfp_write) begin
          state_d = WR_BURST;
        end else if (bus.dfp_read) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read_d = 1'b1;
        if (bus.bmem_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.bmem_rvalid && cnt == LAST_BEAT) begin
          state_d = RESP;
        end
      end
      WR_BURST: begin
        bmem_write_d = 1'b1;
        bmem_wdata_d = wline[cnt*BEAT_W +: BEAT_W];
        if (bus.bmem_ready && cnt == LAST_BEAT) begin
          state_d = RESP;
        end
      end
      RESP: begin
        dfp_resp_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      wline  <= '0;
      rline  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dfp_write) begin
            addr_q <= bus.dfp_addr[31:5];
            wline  <= bus.dfp_wdata;
            cnt    <= '0;
          end else if (bus.dfp_read) begin
            addr_q <= bus.dfp_addr[31:5];
            cnt    <= '0;
          end
        end
        RD_WAIT: begin
          if (bus.bmem_rvalid) begin
            rline[cnt*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
            cnt                         <= cnt + 2'd1;
          end
        end
        WR_BURST: begin
          if (bus.bmem_ready) begin
            cnt <= cnt + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.bmem_addr  = {addr_q, 5'b0};
  assign bus.bmem_read  = bmem_read_d;
  assign bus.bmem_write = bmem_write_d;
  assign bus.bmem_wdata = bmem_wdata_d;
  assign bus.dfp_resp   = dfp_resp_d;
  assign bus.dfp_rdata  = rline;

`ifdef CLA_PERF_CNT_EN
  logic op_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_rd       <= 1'b0;
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.dfp_write) begin
          op_rd <= 1'b0;
        end else if (bus.dfp_read) begin
          op_rd <= 1'b1;
        end
      end
      if (state == RESP) begin
        if (op_rd && perf_rd_cnt != 32'hFFFF_FFFF) begin
          perf_rd_cnt <= perf_rd_cnt + 32'd1;
        end
        if (!op_rd && perf_wr_cnt != 32'hFFFF_FFFF) begin
          perf_wr_cnt <= perf_wr_cnt + 32'd1;
        end
      end
    end
  end
`else
  // No completion counters in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
// ============================================================================
// tb_cacheline_adapter : directed self-checking bench for cacheline_adapter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cacheline_adapter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   resp_seen;

`ifdef CLA_PERF_CNT_EN
  logic [31:0] perf_rd_cnt;
  logic [31:0] perf_wr_cnt;
`endif

  cacheline_adapter_if bus ();

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave)
`ifdef CLA_PERF_CNT_EN
    ,
    .perf_rd_cnt (perf_rd_cnt),
    .perf_wr_cnt (perf_wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.dfp_resp === 1'b1) resp_seen++;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write with optional stall of stall_n extra cycles on beat stall_beat.
  task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                          input int stall_beat, input int stall_n);
    bus.dfp_addr   = a;
    bus.dfp_wdata  = line;
    bus.dfp_write  = 1'b1;
    bus.bmem_ready = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      automatic int reps = (b == stall_beat) ? stall_n : 0;
      for (int s = 0; s <= reps; s++) begin
        chk("wr_valid", {255'd0, bus.bmem_write}, 256'd1);
        chk("wr_beat", {192'd0, bus.bmem_wdata}, {192'd0, line[64*b +: 64]});
        chk("wr_addr", {224'd0, bus.bmem_addr}, {224'd0, a[31:5], 5'b0});
        chk("wr_noresp", {255'd0, bus.dfp_resp}, 256'd0);
        bus.bmem_ready = (s == reps);
        tick();
      end
    end
    chk("wr_resp", {255'd0, bus.dfp_resp}, 256'd1);
    chk("wr_done", {255'd0, bus.bmem_write}, 256'd0);
    bus.dfp_write  = 1'b0;
    bus.bmem_ready = 1'b1;
    tick();
    chk("wr_resp_1cyc", {255'd0, bus.dfp_resp}, 256'd0);
  endtask

  // Read with req_stall not-ready cycles in RD_REQ; gap[b] inserts an idle
  // rvalid cycle before beat b.
  task automatic do_read(input logic [31:0] a, input logic [255:0] line,
                         input int req_stall, input logic [3:0] gap);
    bus.dfp_addr   = a;
    bus.dfp_read   = 1'b1;
    bus.bmem_ready = 1'b1;
    tick();
    for (int s = 0; s <= req_stall; s++) begin
      chk("rd_cmd", {255'd0, bus.bmem_read}, 256'd1);
      chk("rd_addr", {224'd0, bus.bmem_addr}, {224'd0, a[31:5], 5'b0});
      bus.bmem_ready = (s == req_stall);
      tick();
    end
    chk("rd_cmd_drop", {255'd0, bus.bmem_read}, 256'd0);
    bus.bmem_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (gap[b]) begin
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      chk("rd_noresp", {255'd0, bus.dfp_resp}, 256'd0);
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = line[64*b +: 64];
      tick();
    end
    bus.bmem_rvalid = 1'b0;
    chk("rd_resp", {255'd0, bus.dfp_resp}, 256'd1);
    chk("rd_line", bus.dfp_rdata, line);
    bus.dfp_read = 1'b0;
    tick();
    chk("rd_resp_1cyc", {255'd0, bus.dfp_resp}, 256'd0);
    chk("rd_line_hold", bus.dfp_rdata, line);
  endtask

  localparam logic [255:0] W1 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                 64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
  localparam logic [255:0] R1 = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                                 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
  localparam logic [255:0] R2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
  localparam logic [255:0] W2 = {64'h4444_0000_0000_0003, 64'h4444_0000_0000_0002,
                                 64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000};

  int resp_before;

  initial begin
    tests = 0; fails = 0; resp_seen = 0;
    rst = 1'b1;
    bus.dfp_addr = '0; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    tick(); tick();
    chk("rst_resp", {255'd0, bus.dfp_resp}, 256'd0);
    chk("rst_rd", {255'd0, bus.bmem_read}, 256'd0);
    chk("rst_wr", {255'd0, bus.bmem_write}, 256'd0);
    chk("rst_addr", {224'd0, bus.bmem_addr}, 256'd0);
    chk("rst_wdata", {192'd0, bus.bmem_wdata}, 256'd0);
    chk("rst_rdata", bus.dfp_rdata, 256'd0);
    rst = 1'b0;
    tick();

    // Reset after two captured read beats: no response, outputs cleared
    resp_before = resp_seen;
    bus.dfp_addr = 32'h0000_0100; bus.dfp_read = 1'b1; bus.bmem_ready = 1'b1;
    tick();
    chk("abort_cmd", {255'd0, bus.bmem_read}, 256'd1);
    tick();
    bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    bus.bmem_rdata = 64'h0FED_CBA9_8765_4321;
    tick();
    bus.bmem_rvalid = 1'b0; bus.dfp_read = 1'b0; rst = 1'b1;
    tick();
    chk("abort_rdata", bus.dfp_rdata, 256'd0);
    chk("abort_rd", {255'd0, bus.bmem_read}, 256'd0);
    chk("abort_addr", {224'd0, bus.bmem_addr}, 256'd0);
    rst = 1'b0;
    tick(); tick();
    chk("abort_noresp", resp_seen - resp_before, 256'd0);
    do_read(32'h0000_0100, R2, 0, 4'b0000);

    // Plain write, ready always high
    do_write(32'h0000_1234, W1, -1, 0);

    // Plain read, beats at cycles 3,4,6,7
    do_read(32'h8000_0040, R1, 0, 4'b0101);
    chk("rd_after_wr_line", bus.dfp_rdata, R1);

    // Backpressure on write beat 2 and on read command
    do_write(32'h0000_2000, W2, 2, 2);
    chk("wr_keeps_rdata", bus.dfp_rdata, R1);
    do_read(32'h0000_3000, R2, 3, 4'b0000);

    // Simultaneous read and write: write first, then read
    resp_before = resp_seen;
    bus.dfp_read = 1'b1;
    do_write(32'h0000_0040, W1, -1, 0);
    chk("simul_idle_nord", {255'd0, bus.bmem_read}, 256'd0);
    do_read(32'h0000_0040, R1, 0, 4'b0000);
    chk("simul_two_resp", resp_seen - resp_before, 256'd2);

`ifdef CLA_PERF_CNT_EN
    chk("perf_rd", {224'd0, perf_rd_cnt}, 256'd4);
    chk("perf_wr", {224'd0, perf_wr_cnt}, 256'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
